dmem_master: RTL and testbench

DMEM_MASTER -- requirements
Module: dmem_master

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_bus_drv.sv | 10 +
 rtl/dmem_master.sv | 93 +++++++++
 tb/tb_dmem_master.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, bus commands and FSM states for dmem_master.
// DMEM_MASTER_WRITE_VERIFY_EN adds the verify-read states.
package dmem_pkg;
  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;
  localparam logic CMD_READ = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    WR_ISSUE
`ifdef DMEM_MASTER_WRITE_VERIFY_EN
    ,
    VF_ISSUE,
    VF_CAPT
`endif
  } state_t;
endpackage

// File: rtl/dmem_bus_drv.sv
// dmem_bus_drv: tri-state driver for the shared memory data bus.
module dmem_bus_drv
  import dmem_pkg::*;
(
  input  logic               oe,
  input  logic [DMEM_DW-1:0] dout,
  inout  wire  [DMEM_DW-1:0] bus
);
  assign bus = oe ? dout : 'z;
endmodule

// File: rtl/dmem_master.sv
// dmem_master: single-outstanding data-memory access FSM driving a shared bus.
// Define DMEM_MASTER_WRITE_VERIFY_EN to read back every store and flag mismatches.
module dmem_master
  import dmem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [DMEM_AW-1:0] req_addr,
  input  logic [DMEM_DW-1:0] req_wdata,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [DMEM_DW-1:0] resp_rdata,
  output logic               resp_err,
  output logic               mem_cmd,
  output logic [DMEM_AW-1:0] mem_addr,
  inout  wire  [DMEM_DW-1:0] mem_data
);
  state_t state;
  logic [DMEM_DW-1:0] wdata_q;
`ifdef DMEM_MASTER_WRITE_VERIFY_EN
  logic err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif
  dmem_bus_drv u_drv (
    .oe  (mem_cmd == CMD_WRITE),
    .dout(wdata_q),
    .bus (mem_data)
  );
  // mem_addr doubles as the latched request address, so it holds between accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_cmd    <= CMD_READ;
      mem_addr   <= '0;
      wdata_q    <= '0;
`ifdef DMEM_MASTER_WRITE_VERIFY_EN
      err_q      <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            mem_addr  <= req_addr;
            wdata_q   <= req_wdata;
            mem_cmd   <= req_we ? CMD_WRITE : CMD_READ;
            state     <= req_we ? WR_ISSUE : RD_ISSUE;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD_ISSUE: state <= RD_CAPT;
        RD_CAPT: begin
          resp_rdata <= mem_data;
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          state      <= IDLE;
`ifdef DMEM_MASTER_WRITE_VERIFY_EN
          err_q      <= 1'b0;
`endif
        end
        WR_ISSUE: begin
          mem_cmd <= CMD_READ;
`ifdef DMEM_MASTER_WRITE_VERIFY_EN
          state   <= VF_ISSUE;
`else
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          state      <= IDLE;
`endif
        end
`ifdef DMEM_MASTER_WRITE_VERIFY_EN
        VF_ISSUE: state <= VF_CAPT;
        VF_CAPT: begin
          err_q      <= mem_data != wdata_q;
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_master.sv
// tb_dmem_master: directed and random accesses against a registered-read memory model.
module tb_dmem_master;
  import dmem_pkg::*;
`ifdef DMEM_MASTER_WRITE_VERIFY_EN
  localparam bit VF = 1'b1;
`else
  localparam bit VF = 1'b0;
`endif
  localparam int ST_LAT = VF ? 4 : 2;
  localparam int LD_LAT = 3;

  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_cmd;
  logic [7:0] resp_rdata, mem_addr;
  wire  [7:0] mem_data;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] rd_q, last_rdata;
  logic corrupt_en = 1'b0, prev_rv = 1'b0;
  int vectors = 0, fails = 0, pulses = 0, dbl = 0, wr_cycles = 0, completed = 0;

  always #5 clk = ~clk;

  dmem_master dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // memory: writes on cmd=1 (optionally corrupting addr 0x07), registered read otherwise
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      rd_q <= '0;
    end else if (mem_cmd == CMD_WRITE) begin
      mem[mem_addr] <= (corrupt_en && mem_addr == 8'h07) ? 8'h00 : mem_data;
    end else begin
      rd_q <= mem[mem_addr];
    end
  end
  assign mem_data = (mem_cmd == CMD_READ) ? rd_q : 'z;

  always @(posedge clk) begin
    if (resp_valid) pulses++;
    if (resp_valid && prev_rv) dbl++;
    prev_rv = resp_valid;
    if (mem_cmd) wr_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    last_rdata = 8'h00;
  endtask

  // caller is at a negedge; returns at the negedge where resp_valid is seen
  task automatic access(input logic we, input logic [7:0] a, input logic [7:0] d, input logic hold);
    int n, w0;
    logic in_resp;
    logic exp_e;
    in_resp = resp_valid;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_bound", n < 20, 1);
    if (in_resp) check("b2b_same_cycle", n, 0);
    w0 = wr_cycles;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    check("busy_ready", req_ready, 0);
    check("issue_addr", mem_addr, a);
    check("issue_cmd", mem_cmd, we);
    if (we) check("wr_data", mem_data, d);
    n = 1;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check(we ? "st_latency" : "ld_latency", n, we ? ST_LAT : LD_LAT);
    exp_e = VF && we && corrupt_en && a == 8'h07;
    if (we) ref_mem[a] = (corrupt_en && a == 8'h07) ? 8'h00 : d;
    else last_rdata = ref_mem[a];
    check("rdata", resp_rdata, last_rdata);
    check("err", resp_err, exp_e);
    check("wr_cycles", wr_cycles - w0, we);
    check("resp_ready", req_ready, 1);
    completed++;
  endtask

  initial begin
    int w0;
    logic we, hold;
    logic [7:0] a, d;
    int r;
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    check("rst_cmd", mem_cmd, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_oe", dut.u_drv.oe, 0);
    rst_n = 1'b1;
    ref_reset();
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    access(1'b1, 8'h05, 8'h5A, 1'b0);
    access(1'b0, 8'h05, 8'h00, 1'b0);

    access(1'b0, 8'h00, 8'h00, 1'b1);
    access(1'b0, 8'hFF, 8'h00, 1'b1);
    req_valid = 1'b0;

    // a request pulsed while the load is in RD_CAPT must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
    w0 = wr_cycles;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("capt_busy", req_ready, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h99; req_wdata = 8'hEE;
    @(negedge clk);
    req_valid = 1'b0;
    check("capt_resp", resp_valid, 1);
    check("capt_rdata", resp_rdata, 8'h5A);
    completed++;
    last_rdata = 8'h5A;
    repeat (4) begin
      @(negedge clk);
      check("no_extra_resp", resp_valid, 0);
    end
    check("no_extra_write", wr_cycles - w0, 0);

    corrupt_en = 1'b1;
    access(1'b1, 8'h07, 8'h33, 1'b0);
    access(1'b1, 8'h08, 8'h33, 1'b0);
    corrupt_en = 1'b0;
    access(1'b0, 8'h07, 8'h00, 1'b0);

    // reset during RD_ISSUE aborts the load
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h42;
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_addr", mem_addr, 8'h42);
    rst_n = 1'b0;
    #1;
    check("abort_ready", req_ready, 0);
    check("abort_resp", resp_valid, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_rdata", resp_rdata, 0);
    check("abort_cmd", mem_cmd, 0);
    check("abort_oe", dut.u_drv.oe, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_resp", resp_valid, 0);
    end
    rst_n = 1'b1;
    ref_reset();
    @(negedge clk);
    check("ready_after_abort", req_ready, 1);

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 7));
      a = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      d = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      access(we, a, d, hold);
    end
    req_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("resp_pulses", pulses, completed);
    check("resp_double", dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
